// File: rtl/multicycle_ctrl.sv
// Multi-cycle main control FSM: sequences fetch/decode/execute/memory/writeback,
// handshakes with a shared memory and traps on unknown opcodes or memory timeout.
module multicycle_ctrl #(
    parameter int unsigned ALU_OP_W    = 3,
    parameter int unsigned TIMEOUT_W   = 4,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [5:0]          instr_op_i,
    input  logic                mem_ready_i,
    output logic                mem_read_o,
    output logic                mem_write_o,
    output logic                IorD_o,
    output logic                IRWrite_o,
    output logic                PCWrite_o,
    output logic                PCWriteCond_o,
    output logic [1:0]          PCSource_o,
    output logic [ALU_OP_W-1:0] ALU_op_o,
    output logic                ALUSrcA_o,
    output logic [1:0]          ALUSrcB_o,
    output logic                RegDst_o,
    output logic                RegWrite_o,
    output logic                MemtoReg_o,
    output logic                isOri_o,
    output logic                isBne_o,
    output logic [3:0]          state_o,
    output logic                trap_o
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
        S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_REXEC  = 4'd6,  S_RWB   = 4'd7,
        S_BRANCH = 4'd8,  S_JUMP   = 4'd9,  S_IEXEC  = 4'd10, S_IWB   = 4'd11,
        S_TRAP   = 4'd12
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [TIMEOUT_W-1:0] WAIT_LIMIT = TIMEOUT_W'(MEM_TIMEOUT);

    state_e               state_q, state_d;
    logic [5:0]           op_q, op_d;
    logic [TIMEOUT_W-1:0] wait_q, wait_d;
    logic                 wait_expired;

    assign wait_expired = (wait_q == WAIT_LIMIT);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_FETCH;
            op_q    <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        wait_d        = '0;
        mem_read_o    = 1'b0;
        mem_write_o   = 1'b0;
        IorD_o        = 1'b0;
        IRWrite_o     = 1'b0;
        PCWrite_o     = 1'b0;
        PCWriteCond_o = 1'b0;
        PCSource_o    = 2'b00;
        ALU_op_o      = '0;
        ALUSrcA_o     = 1'b0;
        ALUSrcB_o     = 2'b00;
        RegDst_o      = 1'b0;
        RegWrite_o    = 1'b0;
        MemtoReg_o    = 1'b0;
        isOri_o       = 1'b0;
        isBne_o       = 1'b0;
        trap_o        = 1'b0;

        unique case (state_q)
            S_FETCH: begin
                mem_read_o = 1'b1;
                ALUSrcB_o  = 2'b01;
                if (mem_ready_i) begin
                    IRWrite_o = 1'b1;
                    PCWrite_o = 1'b1;
                    state_d   = S_DECODE;
                end else if (wait_expired) begin
                    state_d = S_TRAP;
                end else begin
                    wait_d = wait_q + TIMEOUT_W'(1);
                end
            end
            S_DECODE: begin
                ALUSrcB_o = 2'b11;
                op_d      = instr_op_i;
                case (instr_op_i)
                    OP_RTYPE:                          state_d = S_REXEC;
                    OP_LW, OP_SW:                      state_d = S_MEMADR;
                    OP_BEQ, OP_BNE:                    state_d = S_BRANCH;
                    OP_J:                              state_d = S_JUMP;
                    OP_ADDI, OP_SLTI, OP_LUI, OP_ORI:  state_d = S_IEXEC;
                    default:                           state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA_o = 1'b1;
                ALUSrcB_o = 2'b10;
                state_d   = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_read_o = 1'b1;
                IorD_o     = 1'b1;
                if (mem_ready_i)       state_d = S_MEMWB;
                else if (wait_expired) state_d = S_TRAP;
                else                   wait_d  = wait_q + TIMEOUT_W'(1);
            end
            S_MEMWB: begin
                RegWrite_o = 1'b1;
                MemtoReg_o = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                mem_write_o = 1'b1;
                IorD_o      = 1'b1;
                if (mem_ready_i)       state_d = S_FETCH;
                else if (wait_expired) state_d = S_TRAP;
                else                   wait_d  = wait_q + TIMEOUT_W'(1);
            end
            S_REXEC: begin
                ALUSrcA_o = 1'b1;
                ALU_op_o  = ALU_OP_W'(3'b010);
                state_d   = S_RWB;
            end
            S_RWB: begin
                RegWrite_o = 1'b1;
                RegDst_o   = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA_o     = 1'b1;
                PCWriteCond_o = 1'b1;
                PCSource_o    = 2'b01;
                isBne_o       = (op_q == OP_BNE);
                ALU_op_o      = isBne_o ? ALU_OP_W'(3'b101) : ALU_OP_W'(3'b001);
                state_d       = S_FETCH;
            end
            S_JUMP: begin
                PCWrite_o  = 1'b1;
                PCSource_o = 2'b10;
                state_d    = S_FETCH;
            end
            S_IEXEC, S_IWB: begin
                // ALU_op and isOri stay driven through IWB so the result is held stable
                if (state_q == S_IEXEC) begin
                    ALUSrcA_o = 1'b1;
                    ALUSrcB_o = 2'b10;
                    state_d   = S_IWB;
                end else begin
                    RegWrite_o = 1'b1;
                    state_d    = S_FETCH;
                end
                case (op_q)
                    OP_ADDI: ALU_op_o = ALU_OP_W'(3'b110);
                    OP_SLTI: ALU_op_o = ALU_OP_W'(3'b011);
                    OP_LUI:  ALU_op_o = ALU_OP_W'(3'b100);
                    default: begin
                        ALU_op_o = ALU_OP_W'(3'b111);
                        isOri_o  = 1'b1;
                    end
                endcase
            end
            S_TRAP: begin
                trap_o  = 1'b1;
                state_d = S_TRAP;
            end
            default: state_d = S_TRAP;
        endcase

        // Nothing may be requested or written while reset is being applied
        if (rst_i) begin
            mem_read_o    = 1'b0;
            mem_write_o   = 1'b0;
            IRWrite_o     = 1'b0;
            PCWrite_o     = 1'b0;
            PCWriteCond_o = 1'b0;
            RegWrite_o    = 1'b0;
        end
    end

    assign state_o = state_q;

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle main control unit for the next-generation CPU datapath. Replaces the single-cycle opcode decoder with an FSM that sequences fetch, decode, execute, memory and writeback over several cycles.
- Handshakes with a shared instruction/data memory and supports wait states and a timeout trap.
- Extends the opcode set with lw, sw and j.
- Sits between the IR opcode field and the datapath muxes and enables.

Parameters:
ALU_OP_W, 3, width of ALU_op_o
TIMEOUT_W, 4, width of memory-wait counter
MEM_TIMEOUT, 15, max consecutive wait cycles before trap (must be < 2^TIMEOUT_W)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous active-high reset
instr_op_i  in  6  opcode from IR (valid from DECODE onward)
mem_ready_i  in  1  memory has completed the current read/write this cycle
mem_read_o  out  1  memory read request
mem_write_o  out  1  memory write request
IorD_o  out  1  0=PC address, 1=ALUOut address
IRWrite_o  out  1  load IR
PCWrite_o  out  1  unconditional PC load
PCWriteCond_o  out  1  conditional PC load (branch)
PCSource_o  out  2  00=ALU, 01=ALUOut, 10=jump target
ALU_op_o  out  ALU_OP_W  ALU control code
ALUSrcA_o  out  1  0=PC, 1=rs
ALUSrcB_o  out  2  00=rt, 01=4, 10=imm, 11=imm<<2
RegDst_o  out  1  1=rd, 0=rt
RegWrite_o  out  1  register file write
MemtoReg_o  out  1  1=MDR, 0=ALUOut
isOri_o  out  1  zero-extend immediate
isBne_o  out  1  invert branch condition
state_o  out  4  current state encoding
trap_o  out  1  sticky error flag

Behaviour:

Reset:
- On rst_i=1 at a clock edge: state=FETCH, wait counter=0, trap_o=0, latched opcode=0.
- All enables/requests are 0 in the reset cycle. Reset is valid mid-instruction and abandons the instruction.

States and encodings:
- FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, REXEC=6, RWB=7, BRANCH=8, JUMP=9, IEXEC=10, IWB=11, TRAP=12. Other codes go to TRAP.

Per-state outputs (unlisted outputs are 0):
- FETCH: mem_read_o=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALU_op=000 (add), PCSource=00.
  - When mem_ready_i=1: IRWrite=1, PCWrite=1, next=DECODE.
  - Otherwise stay in FETCH.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALU_op=000. Latch instr_op_i. Next state by opcode:
  - 000000 -> REXEC
  - 100011 (lw) / 101011 (sw) -> MEMADR
  - 000100 / 000101 -> BRANCH
  - 000010 -> JUMP
  - 001000, 001010, 001111, 001101 -> IEXEC
  - any other opcode -> TRAP
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALU_op=000. Next MEMRD for lw, MEMWR for sw.
- MEMRD: mem_read=1, IorD=1. Advance to MEMWB on mem_ready_i.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. Next FETCH.
- MEMWR: mem_write=1, IorD=1. Advance to FETCH on mem_ready_i.
- REXEC: ALUSrcA=1, ALUSrcB=00, ALU_op=010. Next RWB.
- RWB: RegWrite=1, RegDst=1, MemtoReg=0. Next FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, PCWriteCond=1, PCSource=01.
  - ALU_op=001 for beq.
  - ALU_op=101 with isBne=1 for bne.
  - Next FETCH.
- JUMP: PCWrite=1, PCSource=10. Next FETCH.
- IEXEC: ALUSrcA=1, ALUSrcB=10.
  - ALU_op: addi=110, slti=011, lui=100, ori=111 (isOri=1).
  - Next IWB.
- IWB: RegWrite=1, RegDst=0, MemtoReg=0. isOri and ALU_op held from IEXEC. Next FETCH.
- TRAP: all outputs 0, trap_o=1. Stays in TRAP until reset.

Output timing:
- All outputs are combinational from the registered state and latched opcode.
- In FETCH, MEMRD and MEMWR, the write enables also depend on mem_ready_i.

Cycle counts with zero wait states:
- R-type / I-type: 4
- lw: 5
- sw: 4
- beq/bne: 3
- j: 3

Wait counter:
- Increments each cycle the FSM is in FETCH, MEMRD or MEMWR with mem_ready_i=0.
- Clears on any state change and when mem_ready_i=1.
- If the counter equals MEM_TIMEOUT while mem_ready_i=0: next=TRAP.
- mem_ready_i=1 in that same cycle wins, and the transition proceeds normally.

Other boundary rules:
- mem_ready_i is ignored in all states other than FETCH, MEMRD and MEMWR.

Test Plan:
- Reset, then R-type 000000 with mem_ready_i tied 1 -> state_o sequence 0,1,6,7,0. IRWrite/PCWrite pulse in cycle 1, ALU_op=010 in REXEC, RegWrite=1 and RegDst=1 in RWB.
- lw 100011 with mem_ready_i low for 3 cycles in MEMRD -> state stays 3 for 3 cycles. MEMWB asserts RegWrite=1 and MemtoReg=1. Total 8 cycles.
- bne 000101 -> BRANCH outputs ALU_op=101, isBne=1, PCWriteCond=1, PCSource=01. Back to FETCH after 3 cycles.
- mem_ready_i held 0 in FETCH with MEM_TIMEOUT=15 -> state moves to 12 and trap_o=1 after 16 cycles in FETCH. Stays trapped until rst_i.
- Opcode 111111 -> DECODE goes to TRAP, trap_o=1. Assert rst_i one cycle -> state=0, trap_o=0.
- ori 001101, then rst_i asserted during IEXEC -> next cycle state=0 and RegWrite never asserted. A following addi 001000 completes with ALU_op=110.
